// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage 16-bit pipeline: load-use, branch flush and RAM-sharing hazards.
// Optional saturating stall-cycle counter enabled by the PIPE_HAZARD_STALL_CNT_EN macro.
module pipe_hazard_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int REG_W       = 4
) (
  input  logic             pci_clk,
  input  logic             pci_rst,
  input  logic [REG_W-1:0] pci_id_rs,
  input  logic             pci_id_rs_use,
  input  logic [REG_W-1:0] pci_id_rt,
  input  logic             pci_id_rt_use,
  input  logic             pci_ex_load,
  input  logic [REG_W-1:0] pci_ex_dst,
  input  logic             pci_branch_taken,
  input  logic             pci_mem_req_ram,
  output logic             pco_pc_keep,
  output logic             pco_if_id_en,
  output logic             pco_if_id_keep,
  output logic             pco_id_ex_en,
  output logic             pco_id_ex_keep,
  output logic             pco_ex_mem_keep,
  output logic             pco_ram_grant
`ifdef PIPE_HAZARD_STALL_CNT_EN
  ,
  output logic [15:0]      pco_stall_cnt
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e     state_r;
  state_e     state_nxt_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic       structural_s;
  logic       load_use_s;
  logic       rs_hit_s;
  logic       rt_hit_s;

  // FSM state and access-countdown register
  always_ff @(posedge pci_clk or negedge pci_rst) begin
    if (!pci_rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state: a request in IDLE opens an access window that always runs to completion
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (pci_mem_req_ram) begin
          state_nxt_s = ACCESS;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      ACCESS: begin
        if (cnt_r != 4'd0) begin
          state_nxt_s = ACCESS;
          cnt_nxt_s   = cnt_r - 4'd1;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Hazard detection terms
  always_comb begin
    structural_s = (state_r == ACCESS) || ((state_r == IDLE) && pci_mem_req_ram);
    rs_hit_s     = pci_id_rs_use && (pci_id_rs == pci_ex_dst);
    rt_hit_s     = pci_id_rt_use && (pci_id_rt == pci_ex_dst);
    load_use_s   = pci_ex_load && (rs_hit_s || rt_hit_s);
  end

  // Prioritised control outputs; reset forces the idle pattern regardless of inputs
  always_comb begin
    pco_pc_keep     = 1'b0;
    pco_if_id_en    = 1'b1;
    pco_if_id_keep  = 1'b0;
    pco_id_ex_en    = 1'b1;
    pco_id_ex_keep  = 1'b0;
    pco_ex_mem_keep = 1'b0;
    pco_ram_grant   = 1'b0;
    if (!pci_rst) begin
      pco_pc_keep = 1'b0;
    end else if (structural_s) begin
      pco_pc_keep     = 1'b1;
      pco_if_id_keep  = 1'b1;
      pco_id_ex_keep  = 1'b1;
      pco_ex_mem_keep = !((state_r == ACCESS) && (cnt_r == 4'd0));
      pco_ram_grant   = (state_r == ACCESS);
    end else if (load_use_s) begin
      pco_pc_keep    = 1'b1;
      pco_if_id_keep = 1'b1;
      pco_id_ex_en   = 1'b0;
    end else if (pci_branch_taken) begin
      pco_if_id_en = 1'b0;
    end else begin
      pco_pc_keep = 1'b0;
    end
  end

`ifdef PIPE_HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge pci_clk or negedge pci_rst) begin
    if (!pci_rst) begin
      stall_cnt_r <= 16'd0;
    end else if (pco_pc_keep && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign pco_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl against a cycle-window reference model.
module tb_pipe_hazard_ctrl;
  localparam int WAIT_CYCLES = 2;
  localparam int REG_W       = 4;

  logic             pci_clk = 1'b0;
  logic             pci_rst = 1'b0;
  logic [REG_W-1:0] pci_id_rs = '0, pci_id_rt = '0, pci_ex_dst = '0;
  logic             pci_id_rs_use = 1'b0, pci_id_rt_use = 1'b0, pci_ex_load = 1'b0;
  logic             pci_branch_taken = 1'b0, pci_mem_req_ram = 1'b0;
  logic pco_pc_keep, pco_if_id_en, pco_if_id_keep, pco_id_ex_en;
  logic pco_id_ex_keep, pco_ex_mem_keep, pco_ram_grant;
`ifdef PIPE_HAZARD_STALL_CNT_EN
  logic [15:0] pco_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  // Model: position inside the current stall window (-1 = no access in progress)
  int acc_k = -1;
  int stall_m = 0;

  pipe_hazard_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .REG_W(REG_W)) dut (
    .pci_clk(pci_clk), .pci_rst(pci_rst),
    .pci_id_rs(pci_id_rs), .pci_id_rs_use(pci_id_rs_use),
    .pci_id_rt(pci_id_rt), .pci_id_rt_use(pci_id_rt_use),
    .pci_ex_load(pci_ex_load), .pci_ex_dst(pci_ex_dst),
    .pci_branch_taken(pci_branch_taken), .pci_mem_req_ram(pci_mem_req_ram),
    .pco_pc_keep(pco_pc_keep), .pco_if_id_en(pco_if_id_en),
    .pco_if_id_keep(pco_if_id_keep), .pco_id_ex_en(pco_id_ex_en),
    .pco_id_ex_keep(pco_id_ex_keep), .pco_ex_mem_keep(pco_ex_mem_keep),
    .pco_ram_grant(pco_ram_grant)
`ifdef PIPE_HAZARD_STALL_CNT_EN
    , .pco_stall_cnt(pco_stall_cnt)
`endif
  );

  always #5 pci_clk = ~pci_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_pc_keep"}, 32'(pco_pc_keep), 32'd0);
    check_val({tag, "_if_id_en"}, 32'(pco_if_id_en), 32'd1);
    check_val({tag, "_if_id_keep"}, 32'(pco_if_id_keep), 32'd0);
    check_val({tag, "_id_ex_en"}, 32'(pco_id_ex_en), 32'd1);
    check_val({tag, "_id_ex_keep"}, 32'(pco_id_ex_keep), 32'd0);
    check_val({tag, "_ex_mem_keep"}, 32'(pco_ex_mem_keep), 32'd0);
    check_val({tag, "_grant"}, 32'(pco_ram_grant), 32'd0);
  endtask

  // One clock cycle: apply inputs, check outputs against the model, then advance the model
  task automatic run_cycle(input logic req, input logic ld, input logic [REG_W-1:0] rs,
                           input logic rsu, input logic [REG_W-1:0] rt, input logic rtu,
                           input logic [REG_W-1:0] dst, input logic br);
    logic st, lu, fl, e_pc, e_emk, e_gr;
    int k;
    pci_mem_req_ram = req; pci_ex_load = ld; pci_id_rs = rs; pci_id_rs_use = rsu;
    pci_id_rt = rt; pci_id_rt_use = rtu; pci_ex_dst = dst; pci_branch_taken = br;
    #2;
    st    = (acc_k >= 0) || req;
    k     = (acc_k >= 0) ? acc_k : 0;
    lu    = !st && ld && ((rsu && rs == dst) || (rtu && rt == dst));
    fl    = !st && !lu && br;
    e_pc  = st || lu;
    e_emk = st && (k != WAIT_CYCLES);
    e_gr  = (acc_k >= 1);
    check_val("pc_keep", 32'(pco_pc_keep), 32'(e_pc));
    check_val("if_id_en", 32'(pco_if_id_en), 32'(!fl));
    check_val("if_id_keep", 32'(pco_if_id_keep), 32'(e_pc));
    check_val("id_ex_en", 32'(pco_id_ex_en), 32'(!lu));
    check_val("id_ex_keep", 32'(pco_id_ex_keep), 32'(st));
    check_val("ex_mem_keep", 32'(pco_ex_mem_keep), 32'(e_emk));
    check_val("ram_grant", 32'(pco_ram_grant), 32'(e_gr));
`ifdef PIPE_HAZARD_STALL_CNT_EN
    check_val("stall_cnt", 32'(pco_stall_cnt), 32'(stall_m));
`endif
    if (st) acc_k = (k == WAIT_CYCLES) ? -1 : k + 1;
    if (e_pc && stall_m < 65535) stall_m++;
    @(posedge pci_clk);
    #1;
  endtask

  task automatic idle_cycle();
    run_cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    #1;
    check_idle("rst");
    pci_mem_req_ram = 1'b1;
    #1;
    check_idle("rst_forced");
    pci_mem_req_ram = 1'b0;
    @(negedge pci_clk);
    pci_rst = 1'b1;
    @(posedge pci_clk);
    #1;
    idle_cycle();

    // Load-use stall followed by one RAM access: four PC-hold cycles
    run_cycle(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b0);
    check_val("lu_pc_keep_seen", 32'(stall_m), 32'd1);
    run_cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    run_cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    run_cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    idle_cycle();
`ifdef PIPE_HAZARD_STALL_CNT_EN
    check_val("stall_cnt_4", 32'(pco_stall_cnt), 32'd4);
`endif
    // Same load with rs_use cleared: no stall
    run_cycle(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd3, 1'b0);
    // Branch alone, then a single idle cycle
    run_cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    idle_cycle();
    // Access with branch held: flush only after release
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    run_cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    idle_cycle();
    // Back-to-back requests
    for (int i = 0; i < 7; i++) run_cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    idle_cycle();
    idle_cycle();

    // Reset in the middle of an access
    run_cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    run_cycle(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    pci_mem_req_ram = 1'b0;
    #2;
    check_val("pre_rst_grant", 32'(pco_ram_grant), 32'd1);
    pci_rst = 1'b0;
    #1;
    check_val("mid_rst_grant", 32'(pco_ram_grant), 32'd0);
    check_val("mid_rst_pc_keep", 32'(pco_pc_keep), 32'd0);
    acc_k = -1;
    stall_m = 0;
    @(negedge pci_clk);
    pci_rst = 1'b1;
    @(posedge pci_clk);
    #1;
    idle_cycle();
    idle_cycle();

    for (int i = 0; i < 600; i++) begin
      run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                REG_W'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                REG_W'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                REG_W'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
